// File: rtl/kypd_pkg.sv
// Shared definitions for the PmodKYPD keypad path: key codes, debounce
// state encoding and the default scan-window length.
package kypd_pkg;

  localparam int SCAN_CYCLES_DEFAULT = 400000;

  localparam logic [3:0] KEY_CLR = 4'hC;
  localparam logic [3:0] KEY_ENT = 4'hE;
  localparam logic [3:0] KEY_BSP = 4'hF;

  typedef enum logic {
    DEB_RELEASED = 1'b0,
    DEB_PRESSED  = 1'b1
  } deb_state_t;

  function automatic logic is_digit(input logic [3:0] code);
    return (code <= 4'd9);
  endfunction

endpackage

// File: rtl/kypd_debounce.sv
// Window-based debouncer for active-low inputs: any low level inside a scan
// window marks that window as pressed; the state flips after enough agreeing windows.
module kypd_debounce
  import kypd_pkg::*;
#(
  parameter int SCAN_CYCLES    = SCAN_CYCLES_DEFAULT,
  parameter int DEBOUNCE_SCANS = 5,
  parameter int WIDTH          = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] row,
  output logic             press
);

  localparam int WIN_W  = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int STAB_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(SCAN_CYCLES - 1);
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(DEBOUNCE_SCANS);

  logic [WIN_W-1:0]  win_cnt_q, win_cnt_d;
  logic [STAB_W-1:0] stab_cnt_q, stab_cnt_d;
  logic              any_low_q, any_low_d;
  deb_state_t        state_q, state_d;
  logic              win_end;
  logic              sample;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt_q  <= '0;
      stab_cnt_q <= '0;
      any_low_q  <= 1'b0;
      state_q    <= DEB_RELEASED;
    end else begin
      win_cnt_q  <= win_cnt_d;
      stab_cnt_q <= stab_cnt_d;
      any_low_q  <= any_low_d;
      state_q    <= state_d;
    end
  end

  // The current cycle's row level is folded into the window-end sample.
  always_comb begin
    win_end   = (win_cnt_q == WIN_LAST);
    sample    = any_low_q | ~&row;
    win_cnt_d = win_end ? '0 : win_cnt_q + WIN_W'(1);
    any_low_d = win_end ? 1'b0 : sample;
  end

  always_comb begin
    state_d    = state_q;
    stab_cnt_d = stab_cnt_q;
    if (win_end) begin
      if (sample != (state_q == DEB_PRESSED)) begin
        if (stab_cnt_q + STAB_W'(1) == STAB_MAX) begin
          state_d    = (state_q == DEB_PRESSED) ? DEB_RELEASED : DEB_PRESSED;
          stab_cnt_d = '0;
        end else begin
          stab_cnt_d = stab_cnt_q + STAB_W'(1);
        end
      end else begin
        stab_cnt_d = '0;
      end
    end
  end

  always_comb begin
    press = win_end && (state_q == DEB_RELEASED) && (state_d == DEB_PRESSED);
  end

endmodule

// File: rtl/keypad_entry_buffer.sv
// Turns debounced keypad presses into single key events and a 4-digit BCD
// entry buffer with clear, backspace and commit.
module keypad_entry_buffer
  import kypd_pkg::*;
#(
  parameter int SCAN_CYCLES    = SCAN_CYCLES_DEFAULT,
  parameter int DEBOUNCE_SCANS = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  row,
  input  logic [3:0]  key_code,
  output logic        key_valid,
  output logic [3:0]  key_out,
  output logic [15:0] entry,
  output logic [2:0]  digit_cnt,
  output logic        entry_valid,
  output logic [15:0] entry_value,
  output logic        entry_err
);

  logic        press;
  logic        key_valid_q, key_valid_d;
  logic [3:0]  key_out_q, key_out_d;
  logic [15:0] entry_q, entry_d;
  logic [2:0]  digit_cnt_q, digit_cnt_d;
  logic        entry_valid_q, entry_valid_d;
  logic [15:0] entry_value_q, entry_value_d;
  logic        entry_err_q, entry_err_d;

  kypd_debounce #(
    .SCAN_CYCLES   (SCAN_CYCLES),
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS),
    .WIDTH         (4)
  ) u_debounce (
    .clk  (clk),
    .rst_n(rst_n),
    .row  (row),
    .press(press)
  );

  // key_code is only trusted on the press edge; the decoder settled it earlier.
  always_comb begin
    key_valid_d   = 1'b0;
    entry_valid_d = 1'b0;
    entry_err_d   = 1'b0;
    key_out_d     = key_out_q;
    entry_d       = entry_q;
    digit_cnt_d   = digit_cnt_q;
    entry_value_d = entry_value_q;
    if (press) begin
      key_valid_d = 1'b1;
      key_out_d   = key_code;
      if (is_digit(key_code)) begin
        if (digit_cnt_q < 3'd4) begin
          entry_d     = {entry_q[11:0], key_code};
          digit_cnt_d = digit_cnt_q + 3'd1;
        end else begin
          entry_err_d = 1'b1;
        end
      end else begin
        case (key_code)
          KEY_CLR: begin
            entry_d     = '0;
            digit_cnt_d = '0;
          end
          KEY_BSP: begin
            if (digit_cnt_q != 3'd0) begin
              entry_d     = {4'h0, entry_q[15:4]};
              digit_cnt_d = digit_cnt_q - 3'd1;
            end else begin
              entry_err_d = 1'b1;
            end
          end
          KEY_ENT: begin
            if (digit_cnt_q != 3'd0) begin
              entry_value_d = entry_q;
              entry_valid_d = 1'b1;
              entry_d       = '0;
              digit_cnt_d   = '0;
            end else begin
              entry_err_d = 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_valid_q   <= 1'b0;
      key_out_q     <= '0;
      entry_q       <= '0;
      digit_cnt_q   <= '0;
      entry_valid_q <= 1'b0;
      entry_value_q <= '0;
      entry_err_q   <= 1'b0;
    end else begin
      key_valid_q   <= key_valid_d;
      key_out_q     <= key_out_d;
      entry_q       <= entry_d;
      digit_cnt_q   <= digit_cnt_d;
      entry_valid_q <= entry_valid_d;
      entry_value_q <= entry_value_d;
      entry_err_q   <= entry_err_d;
    end
  end

  assign key_valid   = key_valid_q;
  assign key_out     = key_out_q;
  assign entry       = entry_q;
  assign digit_cnt   = digit_cnt_q;
  assign entry_valid = entry_valid_q;
  assign entry_value = entry_value_q;
  assign entry_err   = entry_err_q;

endmodule

// File: tb/tb_keypad_entry_buffer.sv
// Directed bench for keypad_entry_buffer with short scan windows (8 cycles)
// and a two-window debounce, so every event lands on a predictable edge.
module tb_keypad_entry_buffer;

  localparam int SCAN = 8;
  localparam int DEB  = 2;

  logic        clk;
  logic        rst_n;
  logic [3:0]  row;
  logic [3:0]  key_code;
  logic        key_valid;
  logic [3:0]  key_out;
  logic [15:0] entry;
  logic [2:0]  digit_cnt;
  logic        entry_valid;
  logic [15:0] entry_value;
  logic        entry_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int vldCnt = 0;
  int evCnt = 0;
  int errCnt = 0;
  int exclViol = 0;
  int firstVld = -1;
  logic [15:0] lastEv = '0;

  keypad_entry_buffer #(
    .SCAN_CYCLES   (SCAN),
    .DEBOUNCE_SCANS(DEB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .row        (row),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .key_out    (key_out),
    .entry      (entry),
    .digit_cnt  (digit_cnt),
    .entry_valid(entry_valid),
    .entry_value(entry_value),
    .entry_err  (entry_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance n clocks, sampling 1 time unit after each rising edge.
  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (key_valid) begin
        vldCnt++;
        if (firstVld < 0) firstVld = cyc;
      end
      if (entry_valid) begin
        evCnt++;
        lastEv = entry_value;
      end
      if (entry_err) errCnt++;
      if ((entry_valid && entry_err) || ((entry_valid || entry_err) && !key_valid))
        exclViol++;
    end
  endtask

  task automatic alignWindow();
    while (cyc % SCAN != 0) runCycles(1);
  endtask

  task automatic clearCounts();
    vldCnt = 0;
    evCnt = 0;
    errCnt = 0;
    firstVld = -1;
  endtask

  // One clean press held for holdWin windows, then a long enough release.
  task automatic applyStimulus(input logic [3:0] code, input int holdWin);
    clearCounts();
    alignWindow();
    row = 4'b1011;
    key_code = code;
    runCycles(holdWin * SCAN);
    row = 4'b1111;
    runCycles(4 * SCAN);
  endtask

  initial begin
    rst_n = 1'b0;
    row = 4'b1111;
    key_code = 4'h0;
    #23;
    checkOutput("rst_key_valid", key_valid, 0);
    checkOutput("rst_key_out", key_out, 0);
    checkOutput("rst_entry", entry, 0);
    checkOutput("rst_digit_cnt", digit_cnt, 0);
    checkOutput("rst_entry_valid", entry_valid, 0);
    checkOutput("rst_entry_value", entry_value, 0);
    checkOutput("rst_entry_err", entry_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;

    applyStimulus(4'h5, 3);
    checkOutput("single_vld_cnt", vldCnt, 1);
    checkOutput("single_first_cyc", firstVld, 2 * SCAN);
    checkOutput("single_key_out", key_out, 4'h5);
    checkOutput("single_entry", entry, 16'h0005);
    checkOutput("single_digit_cnt", digit_cnt, 1);

    applyStimulus(4'hC, 3);
    checkOutput("clr_entry", entry, 16'h0000);
    checkOutput("clr_digit_cnt", digit_cnt, 0);

    clearCounts();
    alignWindow();
    key_code = 4'h7;
    for (int w = 0; w < 10; w++) begin
      row = (w % 2 == 0) ? 4'b0111 : 4'b1111;
      runCycles(SCAN);
    end
    row = 4'b1111;
    runCycles(2 * SCAN);
    checkOutput("bounce_vld_cnt", vldCnt, 0);
    checkOutput("bounce_key_out_hold", key_out, 4'hC);

    applyStimulus(4'h1, 2);
    applyStimulus(4'h2, 2);
    applyStimulus(4'h3, 2);
    applyStimulus(4'h4, 2);
    checkOutput("fill_entry", entry, 16'h1234);
    checkOutput("fill_digit_cnt", digit_cnt, 4);
    applyStimulus(4'h9, 2);
    checkOutput("full_vld_cnt", vldCnt, 1);
    checkOutput("full_err_cnt", errCnt, 1);
    checkOutput("full_key_out", key_out, 4'h9);
    checkOutput("full_entry", entry, 16'h1234);
    applyStimulus(4'hE, 2);
    checkOutput("commit_ev_cnt", evCnt, 1);
    checkOutput("commit_err_cnt", errCnt, 0);
    checkOutput("commit_pulse_value", lastEv, 16'h1234);
    checkOutput("commit_entry_value", entry_value, 16'h1234);
    checkOutput("commit_entry", entry, 16'h0000);
    checkOutput("commit_digit_cnt", digit_cnt, 0);

    applyStimulus(4'h7, 2);
    applyStimulus(4'h8, 2);
    checkOutput("pre_bsp_entry", entry, 16'h0078);
    applyStimulus(4'hF, 2);
    checkOutput("bsp_entry", entry, 16'h0007);
    checkOutput("bsp_digit_cnt", digit_cnt, 1);
    applyStimulus(4'hC, 2);
    checkOutput("clr2_entry", entry, 16'h0000);
    checkOutput("clr2_digit_cnt", digit_cnt, 0);
    applyStimulus(4'hF, 2);
    checkOutput("bsp_empty_err_cnt", errCnt, 1);
    checkOutput("bsp_empty_entry", entry, 16'h0000);

    applyStimulus(4'hE, 2);
    checkOutput("empty_commit_err_cnt", errCnt, 1);
    checkOutput("empty_commit_ev_cnt", evCnt, 0);
    checkOutput("empty_commit_value", entry_value, 16'h1234);

    applyStimulus(4'h3, 2);
    applyStimulus(4'hA, 2);
    checkOutput("a_vld_cnt", vldCnt, 1);
    checkOutput("a_key_out", key_out, 4'hA);
    checkOutput("a_entry", entry, 16'h0003);
    checkOutput("a_digit_cnt", digit_cnt, 1);

    clearCounts();
    alignWindow();
    row = 4'b1011;
    key_code = 4'h6;
    runCycles(SCAN + 3);
    checkOutput("mid_no_event", vldCnt, 0);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_key_out", key_out, 0);
    checkOutput("midrst_entry", entry, 0);
    checkOutput("midrst_digit_cnt", digit_cnt, 0);
    checkOutput("midrst_entry_value", entry_value, 0);
    checkOutput("midrst_key_valid", key_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    clearCounts();
    runCycles(3 * SCAN);
    checkOutput("postrst_first_cyc", firstVld, 2 * SCAN);
    checkOutput("postrst_vld_cnt", vldCnt, 1);
    checkOutput("postrst_key_out", key_out, 4'h6);
    checkOutput("postrst_entry", entry, 16'h0006);
    row = 4'b1111;
    runCycles(4 * SCAN);

    checkOutput("pulse_exclusivity", exclViol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
